fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sequences the team's dual-port RAM block (port 0 write-only, port 1 registered read) as a circular buffer. It owns the write and read pointers, the occupancy count, full/empty and threshold flags, sticky overflow/underflow errors and a synchronous flush. It sits between a producer/consumer pair and one RAM instance of depth 2^ADDR_WIDTH.

---
 rtl/fifo_ctrl.sv | 104 ++++++++++
 tb/tb_fifo_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: circular-buffer controller for a dual-port RAM.
// Port 0 writes, port 1 does registered reads; flags come from pointers.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] ram_address_0,
  output logic                  ram_chip_enable_0,
  output logic                  ram_write_read_0,
  output logic [DATA_WIDTH-1:0] ram_data_0,
  output logic [ADDR_WIDTH-1:0] ram_address_1,
  output logic                  ram_chip_enable_1,
  output logic                  ram_write_read_1,
  input  logic [DATA_WIDTH-1:0] ram_data_1
);

  localparam logic [ADDR_WIDTH:0] AF_L = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_L = AE_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                rd_valid_q, rd_valid_d;
  logic                push_acc, pop_acc;

  // Extra MSB on each pointer separates full from empty
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= AF_L);
  assign almost_empty = (count <= AE_L);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = ram_data_1;

  assign pop_acc  = rd_en & ~flush & ~empty;
  assign push_acc = wr_en & ~flush & (~full | pop_acc);

  assign ram_chip_enable_0 = push_acc;
  assign ram_write_read_0  = push_acc;
  assign ram_address_0     = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_data_0        = wr_data;
  assign ram_chip_enable_1 = pop_acc;
  assign ram_write_read_1  = 1'b0;
  assign ram_address_1     = rd_ptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rd_valid_d  = pop_acc;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      rd_valid_d  = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + ONE;
      if (wr_en && !push_acc) overflow_d = 1'b1;
      if (rd_en && empty)     underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl at depth 4.
// Includes a behavioural dual-port RAM with registered read.
module tb_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;
  logic [AW-1:0] a0, a1;
  logic          ce0, we0, ce1, we1;
  logic [DW-1:0] d0;
  logic [DW-1:0] q1 = '0;
  logic [DW-1:0] mem [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow),
    .ram_address_0(a0), .ram_chip_enable_0(ce0),
    .ram_write_read_0(we0), .ram_data_0(d0),
    .ram_address_1(a1), .ram_chip_enable_1(ce1),
    .ram_write_read_1(we1), .ram_data_1(q1)
  );

  // Read registers old contents when the write hits the same slot
  always @(posedge clk) begin
    if (ce1) q1 <= mem[a1];
    if (ce0 && we0) mem[a0] <= d0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  logic [DW-1:0] exp_q [4];

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    chk("rst_rdv", 32'(rd_valid), 0);
    chk("we1_tied", 32'(we1), 0);
    rst_n = 1'b1;
    tick();

    // Fill to full
    wr_en = 1'b1;
    wr_data = 8'h11;
    #1;
    chk("push_ce0", 32'(ce0), 1);
    chk("push_addr", 32'(a0), 0);
    tick();
    wr_en = 1'b0;
    push(8'h22);
    push(8'h33);
    chk("af_3", 32'(almost_full), 1);
    chk("cnt_3", 32'(count), 3);
    chk("full_3", 32'(full), 0);
    push(8'h44);
    chk("full_4", 32'(full), 1);
    chk("cnt_4", 32'(count), 4);

    // Push while full is dropped
    wr_en = 1'b1;
    wr_data = 8'h55;
    #1;
    chk("ovf_ce0", 32'(ce0), 0);
    tick();
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_cnt", 32'(count), 4);
    chk("ovf_mem0", 32'(mem[0]), 32'h11);

    // Drain back-to-back
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_vld", 32'(rd_valid), 1);
      chk("drain_dat", 32'(rd_data), 32'(exp_q[i]));
    end
    rd_en = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("unf_set", 32'(underflow), 1);
    chk("unf_novld", 32'(rd_valid), 0);

    // Push+pop on empty: push only
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'hA5;
    #1;
    chk("pe_ce1", 32'(ce1), 0);
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("pe_cnt", 32'(count), 1);
    chk("pe_novld", 32'(rd_valid), 0);
    chk("pe_unf", 32'(underflow), 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pe_vld", 32'(rd_valid), 1);
    chk("pe_dat", 32'(rd_data), 32'hA5);

    // Push+pop on full, write lands on slot being read
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    chk("pf_full", 32'(full), 1);
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h66;
    tick();
    wr_en = 1'b0;
    chk("pf_dat", 32'(rd_data), 32'h11);
    chk("pf_vld", 32'(rd_valid), 1);
    chk("pf_cnt", 32'(count), 4);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pf_drain", 32'(rd_data), 32'(exp_q[i]));
    end
    rd_en = 1'b0;
    chk("pf_empty", 32'(empty), 1);

    // Streaming at occupancy 1 across pointer wraps
    push(8'h80);
    wr_en = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(8'h81 + i);
      tick();
      chk("st_dat", 32'(rd_data), 32'(8'h80 + i));
      chk("st_vld", 32'(rd_valid), 1);
      chk("st_full", 32'(full), 0);
      chk("st_cnt", 32'(count), 1);
    end
    wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
    chk("st_last", 32'(rd_data), 32'h8A);
    chk("st_empty", 32'(empty), 1);

    // Flush with overflow set at count 3
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    push(8'h05);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fl_pre_cnt", 32'(count), 3);
    chk("fl_pre_ovf", 32'(overflow), 1);
    flush = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    chk("fl_ce0", 32'(ce0), 0);
    chk("fl_ce1", 32'(ce1), 0);
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("fl_cnt", 32'(count), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_ovf", 32'(overflow), 0);
    chk("fl_unf", 32'(underflow), 0);
    chk("fl_vld", 32'(rd_valid), 0);

    // Async reset while a pop strobe is up
    push(8'h77);
    push(8'h78);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("ar_vld_pre", 32'(rd_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld", 32'(rd_valid), 0);
    chk("ar_cnt", 32'(count), 0);
    chk("ar_empty", 32'(empty), 1);
    #10;
    rst_n = 1'b1;
    tick();
    chk("ar_after", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
